// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2 stride-2 pooling over a raster-order feature map.
// Max pooling by default; define AVGPOOL_EN for floor-average pooling.
module relu_maxpool #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FMAP_WIDTH     = 26,
  parameter int unsigned FMAP_HEIGHT    = 26,
  parameter int unsigned OUT_ADDR_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [OUT_ADDR_WIDTH-1:0] o_addr,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned ColW     = (FMAP_WIDTH > 1) ? $clog2(FMAP_WIDTH) : 1;
  localparam int unsigned RowW     = (FMAP_HEIGHT > 1) ? $clog2(FMAP_HEIGHT) : 1;
  localparam int unsigned BufDepth = (FMAP_WIDTH / 2 > 0) ? FMAP_WIDTH / 2 : 1;
  localparam int unsigned BufIdxW  = (BufDepth > 1) ? $clog2(BufDepth) : 1;
`ifdef AVGPOOL_EN
  localparam int unsigned BufW     = DATA_WIDTH + 1;
  localparam int unsigned SumW     = DATA_WIDTH + 2;
`else
  localparam int unsigned BufW     = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [ColW-1:0]         col_q;
  logic [RowW-1:0]         row_q;
  logic [DATA_WIDTH-1:0]   h_q;
  logic [BufW-1:0]         rowbuf_q [BufDepth];

  logic                      accept;
  logic                      last_col;
  logic                      last_row;
  logic [DATA_WIDTH-1:0]     r;
  logic [BufIdxW-1:0]        buf_idx;
  logic [BufW-1:0]           pair;
  logic [DATA_WIDTH-1:0]     result;
  logic [OUT_ADDR_WIDTH-1:0] addr;

  always_comb begin
    accept   = (state_q == StRun) && i_valid;
    last_col = (col_q == ColW'(FMAP_WIDTH - 1));
    last_row = (row_q == RowW'(FMAP_HEIGHT - 1));
    r        = i_data[DATA_WIDTH-1] ? '0 : i_data;
    buf_idx  = BufIdxW'(col_q >> 1);
    addr     = OUT_ADDR_WIDTH'(32'(row_q >> 1) * (FMAP_WIDTH / 2) + 32'(col_q >> 1));
  end

`ifdef AVGPOOL_EN
  logic [SumW-1:0] sum;

  always_comb begin
    pair   = BufW'(h_q) + BufW'(r);
    sum    = SumW'(rowbuf_q[buf_idx]) + SumW'(h_q) + SumW'(r);
    result = DATA_WIDTH'(sum >> 2);
  end
`else
  always_comb begin
    pair   = (h_q > r) ? h_q : r;
    result = (rowbuf_q[buf_idx] > pair) ? rowbuf_q[buf_idx] : pair;
  end
`endif

  // Row buffer and h are never reset: every entry is written before it is read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q <= StRun;
            o_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (accept) begin
            if (!col_q[0]) begin
              h_q <= r;
            end else if (!row_q[0]) begin
              rowbuf_q[buf_idx] <= pair;
            end else begin
              o_valid <= 1'b1;
              o_data  <= result;
              o_addr  <= addr;
            end
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q   <= '0;
                state_q <= StDone;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end else begin
                row_q <= row_q + RowW'(1);
              end
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: a 4x4 instance and a 5x5 instance (odd dimensions).
// Expected values follow max pooling, or average pooling when AVGPOOL_EN is defined.
module tb_relu_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_valid, a_ov, a_busy, a_done;
  logic [7:0] a_data, a_od, a_oa;
  logic       b_start, b_valid, b_ov, b_busy, b_done;
  logic [7:0] b_data, b_od, b_oa;

  relu_maxpool #(
    .DATA_WIDTH(8), .FMAP_WIDTH(4), .FMAP_HEIGHT(4), .OUT_ADDR_WIDTH(8)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_valid(a_valid), .i_data(a_data),
    .o_valid(a_ov), .o_data(a_od), .o_addr(a_oa), .o_busy(a_busy), .o_done(a_done)
  );

  relu_maxpool #(
    .DATA_WIDTH(8), .FMAP_WIDTH(5), .FMAP_HEIGHT(5), .OUT_ADDR_WIDTH(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_valid(b_valid), .i_data(b_data),
    .o_valid(b_ov), .o_data(b_od), .o_addr(b_oa), .o_busy(b_busy), .o_done(b_done)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] a_outs[$];
  logic [15:0] b_outs[$];
  int a_done_n = 0;
  int b_done_n = 0;
  logic [7:0] e_inc[4], e_dec[4], e_mod[4], e_b[4], e_zero[4];

  always @(negedge clk) begin
    if (a_ov === 1'b1) a_outs.push_back({a_oa, a_od});
    if (b_ov === 1'b1) b_outs.push_back({b_oa, b_od});
    if (a_done === 1'b1) a_done_n++;
    if (b_done === 1'b1) b_done_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] q[$], input logic [7:0] e[4]);
    check({tag, "_count"}, q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) begin
      check({tag, "_addr_data"}, q[i], {8'(i), e[i]});
    end
  endtask

  task automatic a_send(input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    b_valid = 1'b1;
    b_data  = d;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;
    e_zero = '{8'd0, 8'd0, 8'd0, 8'd0};
`ifdef AVGPOOL_EN
    e_inc = '{8'd2, 8'd4, 8'd10, 8'd12};
    e_dec = '{8'd12, 8'd10, 8'd4, 8'd2};
    e_mod = '{8'd2, 8'd4, 8'd10, 8'd12};
    e_b   = '{8'd3, 8'd5, 8'd13, 8'd15};
`else
    e_inc = '{8'd5, 8'd7, 8'd13, 8'd15};
    e_dec = '{8'd15, 8'd13, 8'd7, 8'd5};
    e_mod = '{8'd4, 8'd7, 8'd13, 8'd15};
    e_b   = '{8'd6, 8'd8, 8'd16, 8'd18};
`endif
    tick(2);
    rst = 1'b0;

    check("rst_valid", a_ov, 0);
    check("rst_data", a_od, 0);
    check("rst_addr", a_oa, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);

    // Contiguous 0..15.
    a_pulse_start();
    check("busy_run", a_busy, 1);
    for (int i = 0; i < 16; i++) a_send(8'(i));
    check("done_last", a_done, 1);
    check("valid_with_done", a_ov, 1);
    tick(1);
    check("busy_after", a_busy, 0);
    check("done_pulse", a_done, 0);
    check("valid_pulse", a_ov, 0);
    check("hold_data", a_od, e_inc[3]);
    check("hold_addr", a_oa, 3);
    check("done_count_inc", a_done_n, 1);
    check_outs("inc", a_outs, e_inc);
    a_outs.delete();

    // Negative inputs are clamped by ReLU.
    a_pulse_start();
    for (int i = 0; i < 16; i++) a_send((i == 5) ? 8'h80 : 8'hFF);
    tick(1);
    check_outs("neg", a_outs, e_zero);
    a_outs.delete();

    // Descending values: earlier samples win the max.
    a_pulse_start();
    for (int i = 0; i < 16; i++) a_send(8'(15 - i));
    tick(1);
    check_outs("dec", a_outs, e_dec);
    a_outs.delete();

    // First window 0,1,4,4.
    a_pulse_start();
    for (int i = 0; i < 16; i++) a_send((i == 5) ? 8'd4 : 8'(i));
    tick(1);
    check_outs("mod", a_outs, e_mod);
    a_outs.delete();

    // Samples before start are dropped; start mid-frame and in DONE is ignored.
    a_send(8'd99);
    a_send(8'd77);
    check("idle_busy", a_busy, 0);
    a_done_n = 0;
    a_pulse_start();
    for (int i = 0; i < 16; i++) begin
      a_send(8'(i));
      if (i == 8) a_pulse_start();
    end
    a_start = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'd200;
    tick(1);
    a_start = 1'b0;
    a_valid = 1'b0;
    tick(1);
    check("start_in_done_busy", a_busy, 0);
    check("idle_start_done_count", a_done_n, 1);
    check_outs("prestart", a_outs, e_inc);
    a_outs.delete();

    // Reset mid-frame aborts it.
    a_done_n = 0;
    a_pulse_start();
    for (int i = 0; i < 9; i++) a_send(8'(i));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_valid", a_ov, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_data", a_od, 0);
    tick(2);
    check("abort_done_count", a_done_n, 0);
    a_outs.delete();
    a_pulse_start();
    for (int i = 0; i < 16; i++) a_send(8'(i));
    tick(1);
    check_outs("after_abort", a_outs, e_inc);
    check("after_abort_done_count", a_done_n, 1);

    // 5x5 with i_valid toggling.
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      b_send(8'(i));
      if (i == 24) begin
        check("b_done_last", b_done, 1);
        check("b_no_valid_last", b_ov, 0);
      end else begin
        tick(1);
      end
    end
    tick(1);
    check("b_busy_after", b_busy, 0);
    check("b_done_count", b_done_n, 1);
    check_outs("w5", b_outs, e_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
